// File: rtl/bullet_pkg.sv
// ============================================================================
// Module      : bullet_pkg
// Description : Shared types and constants for the bullet table controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bullet_pkg;

    localparam int c_Y_LSB      = 0;
    localparam int c_Y_W        = 8;
    localparam int c_X_LSB      = 8;
    localparam int c_X_W        = 8;
    localparam int c_H_LSB      = 16;
    localparam int c_H_W        = 8;
    localparam int c_W_LSB      = 24;
    localparam int c_W_W        = 8;
    localparam int c_COLOR_LSB  = 32;
    localparam int c_COLOR_W    = 3;
    localparam int c_RENDER_BIT = 35;
    localparam int c_ENTRY_W    = 36;

    typedef struct packed {
        logic                 is_render;
        logic [c_COLOR_W-1:0] color;
        logic [c_W_W-1:0]     w;
        logic [c_H_W-1:0]     h;
        logic [c_X_W-1:0]     x;
        logic [c_Y_W-1:0]     y;
    } bullet_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SPAWN = 2'd2
    } bullet_state_t;

    localparam logic [2:0] c_COLOR_WHITE = 3'b000;
    localparam logic [2:0] c_COLOR_GREEN = 3'b001;
    localparam logic [2:0] c_COLOR_BLUE  = 3'b010;

    localparam logic [7:0] c_DEFAULT_WH = 8'h10;
    localparam logic [7:0] c_SPAWN_Y    = 8'd1;

    // Spawn colours rotate white -> green -> blue -> white.
    function automatic logic [2:0] next_color(input logic [2:0] c);
        return (c == c_COLOR_BLUE) ? c_COLOR_WHITE : c + 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bullet_lfsr.sv
// ============================================================================
// Module      : bullet_lfsr
// Description : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with step enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bullet_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    output logic [7:0] o_lfsr
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/bullet_controller.sv
// ============================================================================
// Module      : bullet_controller
// Description : Bullet table with per-frame move sweep, spawner and hit port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bullet_controller
    import bullet_pkg::*;
#(
    parameter int         NUM_BULLETS  = 8,
    parameter int         ARENA_MAX    = 200,
    parameter int         STEP         = 10,
    parameter int         SPAWN_PERIOD = 16,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           isRun,
    input  logic                           frameTick,
    input  logic [$clog2(NUM_BULLETS)-1:0] index1,
    input  logic [$clog2(NUM_BULLETS)-1:0] index2,
    output logic [15:0]                    position1,
    output logic [15:0]                    position2,
    output logic [15:0]                    size1,
    output logic [15:0]                    size2,
    output logic [2:0]                     color1,
    output logic [2:0]                     color2,
    output logic                           isRender1,
    output logic                           isRender2,
    input  logic                           hit,
    input  logic [$clog2(NUM_BULLETS)-1:0] hitIndex,
    output logic                           busy,
    output logic [$clog2(NUM_BULLETS):0]   activeCount,
    output logic                           overrun,
    output logic                           spawnDrop
);

    localparam int                 c_IDX_W    = $clog2(NUM_BULLETS);
    localparam int                 c_CNT_W    = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_BULLETS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SPAWN_PERIOD - 1);

    bullet_state_t      r_state;
    bullet_state_t      w_state_nxt;
    logic               w_start;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_CNT_W-1:0] r_spawn_cnt;
    logic [2:0]         r_color_cnt;
    logic               r_overrun;
    logic               r_spawn_drop;
    logic [7:0]         w_lfsr;
    logic [7:0]         w_spawn_x;

    bullet_entry_t      r_table     [NUM_BULLETS];
    bullet_entry_t      w_table_nxt [NUM_BULLETS];

    logic               w_free_found;
    logic [c_IDX_W-1:0] w_free_idx;
    logic               w_spawn_due;
    logic               w_spawn_go;
    logic [c_IDX_W:0]   w_active_cnt;

    bullet_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst    (reset),
        .i_en   (w_start),
        .o_lfsr (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frameTick && isRun) begin
                    w_state_nxt = ST_SCAN;
                    w_start     = 1'b1;
                end
            end
            ST_SCAN:  if (r_idx == c_LAST_IDX) w_state_nxt = ST_SPAWN;
            ST_SPAWN: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Lowest-index free slot: scan downward so the smallest index wins.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!r_table[i].is_render) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end
        end
    end

    assign w_spawn_due = (r_state == ST_SPAWN) && (r_spawn_cnt == c_CNT_LAST);
    assign w_spawn_go  = w_spawn_due && w_free_found;
    assign w_spawn_x   = (w_lfsr & 8'h7F) + 8'd8;

    // Priority: scan update, then hit (kills and undoes the move), then spawn.
    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_table_nxt[i] = r_table[i];
        end
        if (r_state == ST_SCAN && r_table[r_idx].is_render) begin
            if (({1'b0, r_table[r_idx].y} + 9'(STEP)) > 9'(ARENA_MAX)) begin
                w_table_nxt[r_idx].is_render = 1'b0;
            end else begin
                w_table_nxt[r_idx].y = r_table[r_idx].y + 8'(STEP);
            end
        end
        if (hit) begin
            w_table_nxt[hitIndex]           = r_table[hitIndex];
            w_table_nxt[hitIndex].is_render = 1'b0;
        end
        if (w_spawn_go) begin
            w_table_nxt[w_free_idx] = '{is_render: 1'b1, color: r_color_cnt,
                                        w: c_DEFAULT_WH, h: c_DEFAULT_WH,
                                        x: w_spawn_x, y: c_SPAWN_Y};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx        <= '0;
            r_spawn_cnt  <= '0;
            r_color_cnt  <= c_COLOR_WHITE;
            r_overrun    <= 1'b0;
            r_spawn_drop <= 1'b0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            r_overrun    <= frameTick && (r_state != ST_IDLE);
            r_spawn_drop <= w_spawn_due && !w_free_found;
            if (w_start) begin
                r_idx <= '0;
            end else if (r_state == ST_SCAN) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == ST_SPAWN) begin
                r_spawn_cnt <= w_spawn_due ? '0 : r_spawn_cnt + 1'b1;
            end
            if (w_spawn_go) begin
                r_color_cnt <= next_color(r_color_cnt);
            end
            for (int i = 0; i < NUM_BULLETS; i++) begin
                r_table[i] <= w_table_nxt[i];
            end
        end
    end

    always_comb begin
        w_active_cnt = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_active_cnt = w_active_cnt + (c_IDX_W + 1)'(r_table[i].is_render);
        end
    end

    assign position1   = {r_table[index1].x, r_table[index1].y};
    assign position2   = {r_table[index2].x, r_table[index2].y};
    assign size1       = {r_table[index1].w, r_table[index1].h};
    assign size2       = {r_table[index2].w, r_table[index2].h};
    assign color1      = r_table[index1].color;
    assign color2      = r_table[index2].color;
    assign isRender1   = r_table[index1].is_render;
    assign isRender2   = r_table[index2].is_render;
    assign busy        = (r_state != ST_IDLE);
    assign activeCount = w_active_cnt;
    assign overrun     = r_overrun;
    assign spawnDrop   = r_spawn_drop;

endmodule

`default_nettype wire

// File: tb/tb_bullet_controller.sv
// ============================================================================
// Module      : tb_bullet_controller
// Description : Self-checking bench; two DUTs (spawn period 16 and 1) vs. model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bullet_controller;

    localparam int NB      = 8;
    localparam int c_ARENA = 200;
    localparam int c_STEP  = 10;
    localparam int PERIOD [2] = '{16, 1};

    logic       clk = 1'b0;
    logic       reset = 1'b1, isRun = 1'b0, frameTick = 1'b0, hit = 1'b0;
    logic [2:0] index1 = '0, index2 = '0, hitIndex = '0;

    logic [15:0] position1 [2], position2 [2], size1 [2], size2 [2];
    logic [2:0]  color1 [2], color2 [2];
    logic        isRender1 [2], isRender2 [2], busy [2], overrun [2], spawnDrop [2];
    logic [3:0]  activeCount [2];

    int n_chk = 0, n_pass = 0, drop_cnt1 = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    bullet_controller #(.SPAWN_PERIOD(16)) u_dut0 (
        .clk(clk), .reset(reset), .isRun(isRun), .frameTick(frameTick),
        .index1(index1), .index2(index2),
        .position1(position1[0]), .position2(position2[0]),
        .size1(size1[0]), .size2(size2[0]), .color1(color1[0]), .color2(color2[0]),
        .isRender1(isRender1[0]), .isRender2(isRender2[0]),
        .hit(hit), .hitIndex(hitIndex), .busy(busy[0]), .activeCount(activeCount[0]),
        .overrun(overrun[0]), .spawnDrop(spawnDrop[0]));

    bullet_controller #(.SPAWN_PERIOD(1)) u_dut1 (
        .clk(clk), .reset(reset), .isRun(isRun), .frameTick(frameTick),
        .index1(index1), .index2(index2),
        .position1(position1[1]), .position2(position2[1]),
        .size1(size1[1]), .size2(size2[1]), .color1(color1[1]), .color2(color2[1]),
        .isRender1(isRender1[1]), .isRender2(isRender2[1]),
        .hit(hit), .hitIndex(hitIndex), .busy(busy[1]), .activeCount(activeCount[1]),
        .overrun(overrun[1]), .spawnDrop(spawnDrop[1]));

    // Reference model: table as plain arrays, sweep tracked as cycles remaining.
    bit         m_act [2][NB];
    int         m_x [2][NB], m_y [2][NB], m_col [2][NB], m_wh [2][NB];
    int         m_left [2], m_sweeps [2], m_color [2];
    logic [7:0] m_lfsr [2];
    bit         m_ovr [2], m_drop [2];

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge(input int u);
        bit n_act [NB];
        int n_y [NB];
        int k, fi;
        if (reset) begin
            for (int i = 0; i < NB; i++) begin
                m_act[u][i] = 0; m_x[u][i] = 0; m_y[u][i] = 0; m_col[u][i] = 0; m_wh[u][i] = 0;
            end
            m_left[u] = 0; m_sweeps[u] = 0; m_color[u] = 0; m_lfsr[u] = 8'hA5;
            m_ovr[u] = 0; m_drop[u] = 0;
        end else begin
            m_ovr[u]  = frameTick && (m_left[u] > 0);
            m_drop[u] = 0;
            for (int i = 0; i < NB; i++) begin
                n_act[i] = m_act[u][i];
                n_y[i]   = m_y[u][i];
            end
            k = (m_left[u] > 0) ? 9 - m_left[u] : -1;
            if (k >= 0 && k < NB && m_act[u][k]) begin
                if (m_y[u][k] + c_STEP > c_ARENA) n_act[k] = 0;
                else n_y[k] = m_y[u][k] + c_STEP;
            end
            if (hit) begin
                n_act[hitIndex] = 0;
                n_y[hitIndex]   = m_y[u][hitIndex];
            end
            if (k == NB) begin
                m_sweeps[u]++;
                if (m_sweeps[u] % PERIOD[u] == 0) begin
                    fi = -1;
                    for (int i = NB - 1; i >= 0; i--) if (!m_act[u][i]) fi = i;
                    if (fi < 0) begin
                        m_drop[u] = 1;
                    end else begin
                        n_act[fi] = 1; n_y[fi] = 1;
                        m_x[u][fi]   = int'(m_lfsr[u] & 8'h7F) + 8;
                        m_col[u][fi] = m_color[u];
                        m_wh[u][fi]  = 16;
                        m_color[u]   = (m_color[u] + 1) % 3;
                    end
                end
            end
            for (int i = 0; i < NB; i++) begin
                m_act[u][i] = n_act[i];
                m_y[u][i]   = n_y[i];
            end
            if (m_left[u] > 0) m_left[u]--;
            else if (frameTick && isRun) begin
                m_left[u] = 9;
                m_lfsr[u] = lfsr_next(m_lfsr[u]);
            end
        end
    endtask

    function automatic logic [35:0] exp_entry(input int u, input int i);
        return {m_act[u][i], 3'(m_col[u][i]), 8'(m_wh[u][i]), 8'(m_wh[u][i]),
                8'(m_x[u][i]), 8'(m_y[u][i])};
    endfunction

    always @(posedge clk) begin
        model_edge(0);
        model_edge(1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                check($sformatf("busy%0d", u), 64'(busy[u]), 64'(m_left[u] > 0));
                check($sformatf("overrun%0d", u), 64'(overrun[u]), 64'(m_ovr[u]));
                check($sformatf("spawnDrop%0d", u), 64'(spawnDrop[u]), 64'(m_drop[u]));
                check($sformatf("activeCount%0d", u), 64'(activeCount[u]),
                      64'(m_act[u].sum() with (int'(item))));
                check($sformatf("port1_%0d", u),
                      64'({isRender1[u], color1[u], size1[u], position1[u]}), 64'(exp_entry(u, index1)));
                check($sformatf("port2_%0d", u),
                      64'({isRender2[u], color2[u], size2[u], position2[u]}), 64'(exp_entry(u, index2)));
            end
            if (spawnDrop[1]) drop_cnt1++;
        end
    end

    task automatic do_frame();
        @(posedge clk); #1 frameTick = 1'b1;
        @(posedge clk); #1 frameTick = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk); #1 chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_active", 64'(activeCount[0]), 64'd0);
        check("rst_entry0", 64'({isRender1[0], color1[0], size1[0], position1[0]}), 64'd0);
        reset = 1'b0; isRun = 1'b1;

        repeat (16) do_frame();
        index1 = 3'd0;
        #1;
        check("spawn16_render", 64'(isRender1[0]), 64'd1);
        check("spawn16_color", 64'(color1[0]), 64'd0);
        check("spawn16_size", 64'(size1[0]), 64'h1010);
        check("spawn16_y", 64'(position1[0][7:0]), 64'd1);
        check("spawn16_xrange", 64'(position1[0][15:8] >= 8'd8 && position1[0][15:8] <= 8'd135), 64'd1);
        check("spawn16_active", 64'(activeCount[0]), 64'd1);
        check("p1_full", 64'(activeCount[1]), 64'd8);
        check("p1_drops", 64'(drop_cnt1), 64'd8);

        repeat (19) do_frame();
        check("y191_render", 64'(isRender1[0]), 64'd1);
        check("y191_y", 64'(position1[0][7:0]), 64'd191);
        do_frame();
        check("retire_render", 64'(isRender1[0]), 64'd0);
        check("retire_y", 64'(position1[0][7:0]), 64'd191);

        repeat (12) do_frame();
        index1 = 3'd1; index2 = 3'd0;
        #1;
        check("dual_color1", 64'(color1[0]), 64'd1);
        check("dual_color2", 64'(color2[0]), 64'd2);
        check("dual_y1", 64'(position1[0][7:0]), 64'd161);
        check("dual_y2", 64'(position2[0][7:0]), 64'd1);
        check("dual_active", 64'(activeCount[0]), 64'd2);

        // Kill entry 0 in the same cycle the sweep moves it.
        @(posedge clk); #1 frameTick = 1'b1;
        @(posedge clk); #1 frameTick = 1'b0; hit = 1'b1; hitIndex = 3'd0;
        @(posedge clk); #1 hit = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("hit_render", 64'(isRender2[0]), 64'd0);
        check("hit_y", 64'(position2[0][7:0]), 64'd1);
        check("hit_other_y", 64'(position1[0][7:0]), 64'd171);

        // Second tick mid-sweep, then reset while still busy.
        @(posedge clk); #1 frameTick = 1'b1;
        @(posedge clk); #1 frameTick = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 frameTick = 1'b1;
        @(posedge clk); #1 frameTick = 1'b0;
        check("ovr_pulse", 64'(overrun[0]), 64'd1);
        check("ovr_busy", 64'(busy[0]), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("rst2_busy", 64'(busy[0]), 64'd0);
        check("rst2_active", 64'(activeCount[0] + activeCount[1]), 64'd0);
        check("rst2_entry1", 64'({isRender1[0], color1[0], size1[0], position1[0]}), 64'd0);

        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #1;
            frameTick = ($urandom_range(0, 11) == 0);
            isRun     = ($urandom_range(0, 9) != 0);
            hit       = ($urandom_range(0, 19) == 0);
            hitIndex  = 3'($urandom);
            index1    = 3'($urandom);
            index2    = 3'($urandom);
            reset     = ($urandom_range(0, 2499) == 0);
        end
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
